// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : Buffered UART transmitter (8 data bits, optional parity, 1/2 stop)
//            with a small byte FIFO; each bit lasts i_baud_div+1 clocks.
// Revision : 1.0
// ============================================================================
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [15:0]                   i_baud_div,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int                c_addr_w = $clog2(FIFO_DEPTH);
    localparam int                c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);
    localparam logic [2:0]         c_last_stop = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]          fifo_q [FIFO_DEPTH];
    logic [c_addr_w-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_cnt_w-1:0]  count_q;

    // Frame engine
    state_t      state_q,   state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [15:0] baud_q,    baud_d;
    logic [7:0]  shift_q,   shift_d;
    logic [2:0]  bit_q,     bit_d;
    logic        par_q,     par_d;
    logic        tx_q,      tx_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;

    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_bit_end;
    logic [7:0]  w_head;

    assign o_ready      = ~i_rst & (count_q != c_depth);
    assign w_push       = i_valid & o_ready;
    assign w_empty      = (count_q == '0);
    assign w_head       = fifo_q[rd_ptr_q];
    assign w_bit_end    = (clk_cnt_q == baud_q);
    assign o_fifo_count = count_q;
    assign o_tx         = tx_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + c_addr_w'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + c_addr_w'(1);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_cnt_w'(1);
                2'b01:   count_q <= count_q - c_cnt_w'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        baud_d    = baud_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        par_d     = par_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        w_pop     = 1'b0;

        // Compare-then-clear keeps the counter below baud_q+1, so 16'hFFFF never wraps.
        if (state_q != S_IDLE) begin
            clk_cnt_d = w_bit_end ? 16'd0 : clk_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                w_pop = ~w_empty;
            end
            S_START: begin
                if (w_bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                            bit_d   = 3'd0;
                        end
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    bit_d   = 3'd0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (bit_q == c_last_stop) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        w_pop   = ~w_empty;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A frame load (from IDLE or straight out of STOP) overrides the above.
        if (w_pop) begin
            state_d   = S_START;
            tx_d      = 1'b0;
            shift_d   = w_head;
            baud_d    = i_baud_div;
            clk_cnt_d = 16'd0;
            par_d     = (^w_head) ^ (PARITY_ODD != 0);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            baud_q    <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            baud_q    <= baud_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx in 8N1, 8E1 and 8O2 builds against
//            a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx;

    localparam int DEPTH = 4;
    localparam int PEN   [3] = '{0, 1, 1};
    localparam int PODD  [3] = '{0, 0, 1};
    localparam int NSTOP [3] = '{1, 1, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic [15:0] baud;

    logic        ready_w [3];
    logic        tx_w    [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic [2:0]  cnt_w   [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.FIFO_DEPTH(DEPTH), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_n1 (
        .i_clk(clk), .i_rst(rst), .i_baud_div(baud), .i_data(data), .i_valid(valid),
        .o_ready(ready_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]),
        .o_fifo_count(cnt_w[0]));

    uart_tx #(.FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_e1 (
        .i_clk(clk), .i_rst(rst), .i_baud_div(baud), .i_data(data), .i_valid(valid),
        .o_ready(ready_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]),
        .o_fifo_count(cnt_w[1]));

    uart_tx #(.FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut_o2 (
        .i_clk(clk), .i_rst(rst), .i_baud_div(baud), .i_data(data), .i_valid(valid),
        .o_ready(ready_w[2]), .o_tx(tx_w[2]), .o_busy(busy_w[2]), .o_done(done_w[2]),
        .o_fifo_count(cnt_w[2]));

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, d, $time, act, exp);
        end
    endtask

    // Line level at clock 'pos' of a frame carrying byte b with bit period p.
    function automatic bit lvl(input int d, input logic [7:0] b, input int pos, input int p);
        int k;
        k = pos / p;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && PEN[d] != 0) return (^b) ^ PODD[d][0];
        return 1'b1;
    endfunction

    // Reference model: queue of pending bytes plus position inside the current frame.
    logic [7:0] mq [3][$];
    logic [7:0] mbyte [3];
    int  mpos [3];
    int  mlen [3];
    int  mper [3];
    bit  min  [3] = '{0, 0, 0};
    bit  etx  [3] = '{1, 1, 1};
    bit  ebusy[3] = '{0, 0, 0};
    bit  edone[3] = '{0, 0, 0};

    always @(posedge clk) begin
        int pre;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                mq[d].delete();
                min[d]   = 1'b0;
                etx[d]   = 1'b1;
                ebusy[d] = 1'b0;
                edone[d] = 1'b0;
            end else begin
                pre      = mq[d].size();
                edone[d] = 1'b0;
                if (min[d]) begin
                    mpos[d]++;
                    if (mpos[d] == mlen[d]) begin
                        min[d]   = 1'b0;
                        edone[d] = 1'b1;
                    end
                end
                if (!min[d] && pre != 0) begin
                    mbyte[d] = mq[d].pop_front();
                    mper[d]  = int'(baud) + 1;
                    mlen[d]  = (9 + PEN[d] + NSTOP[d]) * mper[d];
                    mpos[d]  = 0;
                    min[d]   = 1'b1;
                end
                if (valid && pre != DEPTH) mq[d].push_back(data);
                etx[d]   = min[d] ? lvl(d, mbyte[d], mpos[d], mper[d]) : 1'b1;
                ebusy[d] = min[d];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk("tx",    d, int'(tx_w[d]),    int'(etx[d]));
                chk("busy",  d, int'(busy_w[d]),  int'(ebusy[d]));
                chk("done",  d, int'(done_w[d]),  int'(edone[d]));
                chk("count", d, int'(cnt_w[d]),   mq[d].size());
                chk("ready", d, int'(ready_w[d]), int'(!rst && mq[d].size() != DEPTH));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    bit        cap_tx   [3][64];
    bit        cap_done [3][64];
    int        nbusy    [3];
    int        ndone    [3];
    int        done_at;
    logic [9:0] seq;
    int        flen [3] = '{40, 44, 48};
    int        blen [3] = '{50, 55, 60};

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        baud  = 16'd3;
        repeat (3) step();
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", d, int'(ready_w[d]), 0);
            chk("rst_tx",    d, int'(tx_w[d]),    1);
            chk("rst_busy",  d, int'(busy_w[d]),  0);
            chk("rst_count", d, int'(cnt_w[d]),   0);
        end
        step();
        rst = 1'b0;
        step();

        // Single 0xA5 frame at 4 clocks per bit
        valid = 1'b1;
        data  = 8'hA5;
        baud  = 16'd3;
        step();
        valid = 1'b0;
        for (int d = 0; d < 3; d++) begin
            nbusy[d] = 0;
            ndone[d] = 0;
        end
        done_at = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                cap_tx[d][n]   = tx_w[d];
                cap_done[d][n] = done_w[d];
                nbusy[d] += int'(busy_w[d]);
                ndone[d] += int'(done_w[d]);
            end
            if (done_w[0] && done_at < 0) done_at = n;
        end
        step();
        seq = 10'b1101001010;
        chk("latency_idle", 0, int'(cap_tx[0][0]), 1);
        for (int i = 0; i < 10; i++) begin
            chk("a5_bit_first", i, int'(cap_tx[0][1 + 4 * i]), int'(seq[i]));
            chk("a5_bit_last",  i, int'(cap_tx[0][4 + 4 * i]), int'(seq[i]));
        end
        for (int d = 0; d < 3; d++) begin
            chk("frame_len",  d, nbusy[d], flen[d]);
            chk("done_count", d, ndone[d], 1);
        end
        chk("done_when", 0, done_at, 41);
        chk("even_par", 1, int'(cap_tx[1][37]), 0);
        chk("odd_par",  2, int'(cap_tx[2][37]), 1);
        chk("stop1",    2, int'(cap_tx[2][41]), 1);
        chk("stop2",    2, int'(cap_tx[2][45]), 1);
        chk("idle_aft", 2, int'(cap_tx[2][49]), 1);

        // Five back-to-back bytes at one clock per bit
        baud  = 16'd0;
        valid = 1'b1;
        data  = 8'($urandom);
        for (int d = 0; d < 3; d++) begin
            nbusy[d] = 0;
            ndone[d] = 0;
        end
        for (int n = 0; n < 90; n++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                nbusy[d] += int'(busy_w[d]);
                ndone[d] += int'(done_w[d]);
            end
            if (n == 5) begin
                for (int d = 0; d < 3; d++) begin
                    chk("full_count", d, int'(cnt_w[d]),   4);
                    chk("full_ready", d, int'(ready_w[d]), 0);
                end
            end
            @(posedge clk);
            #2;
            data = 8'($urandom);
            if (n == 4) valid = 1'b0;
        end
        for (int d = 0; d < 3; d++) begin
            chk("b2b_busy", d, nbusy[d], blen[d]);
            chk("b2b_done", d, ndone[d], 5);
        end

        // Reset in the middle of a data bit
        baud  = 16'd3;
        valid = 1'b1;
        data  = 8'h5A;
        step();
        data  = 8'hC3;
        step();
        valid = 1'b0;
        repeat (14) step();
        rst = 1'b1;
        step();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("abort_tx",    d, int'(tx_w[d]),   1);
            chk("abort_busy",  d, int'(busy_w[d]), 0);
            chk("abort_count", d, int'(cnt_w[d]),  0);
        end
        step();
        rst   = 1'b0;
        valid = 1'b1;
        data  = 8'h3C;
        step();
        valid = 1'b0;
        repeat (60) step();

        // Random traffic with bit periods of 1..21 clocks
        baud = 16'($urandom_range(0, 20));
        for (int n = 0; n < 8000; n++) begin
            valid = ($urandom_range(0, 2) == 0);
            data  = 8'($urandom);
            if ($urandom_range(0, 40) == 0) baud = 16'($urandom_range(0, 20));
            rst   = ($urandom_range(0, 2999) == 0);
            step();
        end
        rst   = 1'b0;
        valid = 1'b0;
        repeat (1400) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
